// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack pipeline input among N
// requesters; latches the winner's data word and closes both handshakes in turn.
module handshake_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   src_req,
    output logic [N-1:0]   src_ack,
    input  logic [N*W-1:0] src_data,
    output logic           pipe_req,
    input  logic           pipe_ack,
    output logic [W-1:0]   pipe_data,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [15:0]    xfer_count
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RELEASE, ACK} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx_q;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  src_ack_q;
    logic          pipe_req_q;
    logic [W-1:0]  pipe_data_q;
    logic [15:0]   xfer_count_q;

    logic          win_valid;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;

    // Scan downward so the candidate closest to ptr (lowest offset) wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (src_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_d = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all registers, pipe_data included, clear asynchronously so outputs drop without a clock.
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gidx_q       <= '0;
            grant_q      <= '0;
            src_ack_q    <= '0;
            pipe_req_q   <= 1'b0;
            pipe_data_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        gidx_q      <= win_idx;
                        grant_q     <= N'(1) << win_idx;
                        pipe_data_q <= src_data[win_idx*W +: W];
                        pipe_req_q  <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (pipe_ack) begin
                        pipe_req_q <= 1'b0;
                        state_q    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!pipe_ack) begin
                        src_ack_q <= grant_q;
                        state_q   <= ACK;
                    end
                end
                ACK: begin
                    if (!src_req[gidx_q]) begin
                        src_ack_q    <= '0;
                        grant_q      <= '0;
                        ptr_q        <= ptr_d;
                        xfer_count_q <= xfer_count_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_ack    = src_ack_q;
    assign pipe_req   = pipe_req_q;
    assign pipe_data  = pipe_data_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: expected grants are queued as requests
// are raised and checked when the arbiter raises pipe_req.
module tb_handshake_arbiter;
    localparam int N       = 4;
    localparam int W       = 16;
    localparam int ACK_DLY = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src_req;
    logic [N-1:0]   src_ack;
    logic [N*W-1:0] src_data;
    logic           pipe_req;
    logic           pipe_ack;
    logic [W-1:0]   pipe_data;
    logic [N-1:0]   grant;
    logic           busy;
    logic [15:0]    xfer_count;

    handshake_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req    (src_req),
        .src_ack    (src_ack),
        .src_data   (src_data),
        .pipe_req   (pipe_req),
        .pipe_ack   (pipe_ack),
        .pipe_data  (pipe_data),
        .grant      (grant),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           total = 0;
    int           bad   = 0;
    int           ack_cnt = 0;
    int           cur_idx = 0;
    logic [W-1:0] cur_data = '0;
    logic         prev_req = 1'b0;
    logic [N-1:0] prev_ack = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance past the edge, then run the pipeline and requester models.
    task automatic step();
        @(posedge clk);
        #1;
        if (pipe_req && !pipe_ack) begin
            ack_cnt++;
            if (ack_cnt >= ACK_DLY) begin
                pipe_ack = 1'b1;
                ack_cnt  = 0;
            end
        end else if (!pipe_req) begin
            pipe_ack = 1'b0;
            ack_cnt  = 0;
        end
        for (int i = 0; i < N; i++)
            if (src_ack[i] && src_req[i]) src_req[i] = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((src_req != '0 || busy || sb.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(src_req == '0 && !busy && sb.size() == 0), 1);
    endtask

    task automatic wait_pipe_req(input string tag, input int budget);
        int n = 0;
        while (!pipe_req && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(pipe_req), 1);
    endtask

    task automatic push(input int idx, input logic [W-1:0] data);
        exp_t x;
        x.idx  = idx;
        x.data = data;
        sb.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'(src_ack), 0);
        check({tag, "_preq"},  32'(pipe_req), 0);
        check({tag, "_pdata"}, 32'(pipe_data), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_cnt"},   32'(xfer_count), 0);
    endtask

    // Reset asserted between edges; models cleared; released after one edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        src_req  = '0;
        pipe_ack = 1'b0;
        ack_cnt  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: grant/data on each new pipe_req, data hold during SEND, ack targeting.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            prev_ack = '0;
        end else begin
            if (pipe_req && !prev_req) begin
                if (sb.size() == 0) begin
                    check("spurious_grant", 1, 0);
                end else begin
                    e        = sb.pop_front();
                    cur_idx  = e.idx;
                    cur_data = e.data;
                    check("grant", 32'(grant), 32'(1 << e.idx));
                    check("pdata", 32'(pipe_data), 32'(e.data));
                end
            end else if (pipe_req) begin
                check("pdata_hold", 32'(pipe_data), 32'(cur_data));
            end
            if (|(src_ack & ~prev_ack)) begin
                check("ack_target", 32'(src_ack), 32'(1 << cur_idx));
                check("ack_after_pipe", 32'(pipe_ack), 0);
            end
            if (busy) begin
                check("ack_onehot", 32'($onehot0(src_ack)), 1);
                check("ack_iso", 32'(src_ack & ~grant), 0);
            end
            prev_req = pipe_req;
            prev_ack = src_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        src_req  = '0;
        src_data = '0;
        pipe_ack = 1'b0;
        #1;
        check_all_zero("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single transfer with one-edge arbitration latency.
        src_data[0*W +: W] = 16'hA1A1;
        push(0, 16'hA1A1);
        src_req[0] = 1'b1;
        check("lat_pre", 32'(pipe_req), 0);
        step();
        check("lat_req", 32'(pipe_req), 1);
        check("lat_grant", 32'(grant), 32'h1);
        check("lat_busy", 32'(busy), 1);
        wait_done("single_done", 50);
        check("cnt_single", 32'(xfer_count), 1);
        check("idle_busy", 32'(busy), 0);

        // From reset, all four at once: served 0,1,2,3.
        do_reset();
        src_data[0*W +: W] = 16'hA1A1;
        src_data[1*W +: W] = 16'hB2B2;
        src_data[2*W +: W] = 16'hC3C3;
        src_data[3*W +: W] = 16'hD4D4;
        for (int i = 0; i < N; i++) push(i, src_data[i*W +: W]);
        src_req = 4'hF;
        wait_done("all4_done", 200);
        check("cnt_all4", 32'(xfer_count), 4);
        check("pdata_keep", 32'(pipe_data), 32'hD4D4);

        // Fairness: after 1 completes, 0 and 2 together -> 2 then 0.
        push(1, 16'hB2B2);
        src_req[1] = 1'b1;
        wait_done("fair1_done", 50);
        push(2, 16'hC3C3);
        push(0, 16'hA1A1);
        src_req = 4'b0101;
        wait_done("fair_done", 100);
        check("cnt_fair", 32'(xfer_count), 7);

        // Data isolation: src_data[0] changes while in SEND.
        push(0, 16'hA1A1);
        src_req[0] = 1'b1;
        wait_pipe_req("iso_req", 20);
        src_data[0*W +: W] = 16'hFFFF;
        wait_done("iso_done", 50);
        check("iso_pdata_after", 32'(pipe_data), 32'hA1A1);
        check("cnt_iso", 32'(xfer_count), 8);

        // Reset mid-SEND; afterwards arbitration restarts at ptr=0 (0 before 3).
        push(3, 16'hD4D4);
        src_req[3] = 1'b1;
        wait_pipe_req("rst_req", 20);
        do_reset();
        src_data[0*W +: W] = 16'h5A5A;
        push(0, 16'h5A5A);
        push(3, 16'hD4D4);
        src_req = 4'b1001;
        wait_done("post_rst_done", 100);
        check("cnt_post_rst", 32'(xfer_count), 2);

        // Counter wrap from a preloaded 0xFFFF.
        force dut.xfer_count_q = 16'hFFFF;
        #1;
        release dut.xfer_count_q;
        check("cnt_forced", 32'(xfer_count), 32'hFFFF);
        push(2, 16'hC3C3);
        src_req[2] = 1'b1;
        wait_done("wrap_done", 50);
        check("cnt_wrap", 32'(xfer_count), 0);
        push(1, 16'hB2B2);
        src_req[1] = 1'b1;
        wait_done("wrap2_done", 50);
        check("cnt_wrap2", 32'(xfer_count), 1);

        // Requester drops req before its ack: transfer still completes and counts.
        push(3, 16'hD4D4);
        src_req[3] = 1'b1;
        wait_pipe_req("early_req", 20);
        src_req[3] = 1'b0;
        wait_done("early_done", 50);
        check("cnt_early", 32'(xfer_count), 2);
        check("early_ack_clr", 32'(src_ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
